// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - Core, host-monitor and fault signals seen by sram_responder.
interface sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [7:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;
  logic        log_valid;
  logic        log_ready;
  logic [7:0]  log_wen;
  logic [31:0] log_waddr;
  logic [63:0] log_wdata;
  logic        log_overflow;
  logic        err_oob;
  logic [31:0] err_addr;

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  log_ready,
    output inst_sram_rdata, data_sram_rdata,
    output log_valid, log_wen, log_waddr, log_wdata, log_overflow,
    output err_oob, err_addr
  );

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output log_ready,
    input  inst_sram_rdata, data_sram_rdata,
    input  log_valid, log_wen, log_waddr, log_wdata, log_overflow,
    input  err_oob, err_addr
  );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - Inst/data SRAM responder over a shared 64-bit array with
// out-of-range fault capture and a first-word-fall-through write-log FIFO.
module sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LOG_DEPTH   = 8
) (
  input logic               clock,
  input logic               reset,
  sram_responder_if.slave   bus
);
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam int          LW      = $clog2(LOG_DEPTH);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 8);
  localparam logic [LW:0] PTR_ONE = (LW + 1)'(1);

  logic [63:0]  mem     [DEPTH_WORDS];
  logic [103:0] log_mem [LOG_DEPTH];

  logic [31:0]   inst_off, data_off;
  logic          inst_in, data_in, inst_oob, data_oob;
  logic [AW-1:0] inst_idx, data_idx;
  logic [63:0]   inst_word, data_word;
  logic          full, empty, pop, push, push_ok;
  logic [103:0]  head;

  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [63:0] data_rdata_q, data_rdata_d;
  logic [LW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d, err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic unused;
  assign unused = ^{bus.inst_sram_wen, bus.inst_sram_wdata};

  // Wrap-around subtraction makes addresses below the base land far out of range.
  assign inst_off  = bus.inst_sram_addr - ADDR_BASE;
  assign data_off  = bus.data_sram_addr - ADDR_BASE;
  assign inst_in   = inst_off < SPAN;
  assign data_in   = data_off < SPAN;
  assign inst_oob  = bus.inst_sram_en & ~inst_in;
  assign data_oob  = bus.data_sram_en & ~data_in;
  assign inst_idx  = inst_off[AW+2:3];
  assign data_idx  = data_off[AW+2:3];
  assign inst_word = mem[inst_idx];
  assign data_word = mem[data_idx];

  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[LW] != rd_ptr_q[LW]) && (wr_ptr_q[LW-1:0] == rd_ptr_q[LW-1:0]);
  assign pop     = ~empty & bus.log_ready;
  assign push    = bus.data_sram_en & data_in & (|bus.data_sram_wen);
  assign push_ok = push & (~full | pop);
  assign head    = log_mem[rd_ptr_q[LW-1:0]];

  always_comb begin
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    err_addr_d   = err_addr_q;
    if (bus.inst_sram_en)
      inst_rdata_d = !inst_in ? 32'h0 :
                     bus.inst_sram_addr[2] ? inst_word[63:32] : inst_word[31:0];
    if (bus.data_sram_en)
      data_rdata_d = data_in ? data_word : 64'h0;
    err_d = err_q | inst_oob | data_oob;
    if (!err_q && data_oob)
      err_addr_d = bus.data_sram_addr;
    else if (!err_q && inst_oob)
      err_addr_d = bus.inst_sram_addr;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = ovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (bus.data_sram_en && data_in) begin
      for (int i = 0; i < 8; i++)
        if (bus.data_sram_wen[i])
          mem[data_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
    end
    if (push_ok)
      log_mem[wr_ptr_q[LW-1:0]] <= {bus.data_sram_wen, bus.data_sram_addr[31:3], 3'b000,
                                    bus.data_sram_wdata};
  end

  assign bus.inst_sram_rdata = inst_rdata_q;
  assign bus.data_sram_rdata = data_rdata_q;
  assign bus.log_valid       = ~empty;
  assign bus.log_wen         = head[103:96];
  assign bus.log_waddr       = head[95:64];
  assign bus.log_wdata       = head[63:0];
  assign bus.log_overflow    = ovf_q;
  assign bus.err_oob         = err_q;
  assign bus.err_addr        = err_addr_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - Scoreboard bench for sram_responder with a word-level reference model.
module tb_sram_responder;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          LDEPTH = 8;
  localparam logic [31:0] SPAN   = 32'(DEPTH * 8);
  localparam int          WIN    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sram_responder_if bus();

  sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LOG_DEPTH(LDEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0]  q_inst [$];
  logic [63:0]  q_data [$];
  logic [103:0] q_log  [$];
  logic [63:0]  mmem   [int];

  int          mcount = 0;
  bit          m_ovf = 0, m_err = 0;
  logic [31:0] m_erra = '0;
  int          vis_count = 0;
  bit          vis_ovf = 0, vis_err = 0;
  logic [31:0] vis_erra = '0;
  bit          inst_pend = 0, data_pend = 0;

  function automatic void chk(string name, logic [103:0] act, logic [103:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: DUT produced a response with nothing expected", name);
  endfunction

  always @(posedge clock) begin
    inst_pend <= bus.inst_sram_en && !reset;
    data_pend <= bus.data_sram_en && !reset;
  end

  always @(negedge clock) begin
    if (inst_pend) begin
      if (q_inst.size() == 0) fail_now("inst_rdata");
      else chk("inst_rdata", bus.inst_sram_rdata, q_inst.pop_front());
    end
    if (data_pend) begin
      if (q_data.size() == 0) fail_now("data_rdata");
      else chk("data_rdata", bus.data_sram_rdata, q_data.pop_front());
    end
    chk("log_valid", bus.log_valid, vis_count != 0);
    if (bus.log_valid && bus.log_ready) begin
      if (q_log.size() == 0) fail_now("log_entry");
      else chk("log_entry", {bus.log_wen, bus.log_waddr, bus.log_wdata}, q_log.pop_front());
    end
    chk("log_overflow", bus.log_overflow, vis_ovf);
    chk("err_oob", bus.err_oob, vis_err);
    chk("err_addr", bus.err_addr, vis_erra);
  end

  task automatic cyc(bit ie, logic [31:0] ia, bit de, logic [7:0] dw, logic [31:0] da,
                     logic [63:0] dd, bit rdy);
    logic [31:0] off;
    logic [63:0] w;
    bit io = 0, dox = 0, din = 0, pop, push;
    bus.inst_sram_en    = ie;
    bus.inst_sram_addr  = ia;
    bus.inst_sram_wen   = 4'($urandom);
    bus.inst_sram_wdata = $urandom;
    bus.data_sram_en    = de;
    bus.data_sram_wen   = dw;
    bus.data_sram_addr  = da;
    bus.data_sram_wdata = dd;
    bus.log_ready       = rdy;
    if (ie) begin
      off = ia - BASE;
      if (off < SPAN) begin
        w = mmem[int'(off >> 3)];
        q_inst.push_back(ia[2] ? w[63:32] : w[31:0]);
      end else begin
        q_inst.push_back('0);
        io = 1;
      end
    end
    if (de) begin
      off = da - BASE;
      din = off < SPAN;
      if (din) begin
        w = mmem[int'(off >> 3)];
        q_data.push_back(w);
        for (int i = 0; i < 8; i++)
          if (dw[i]) w[8*i +: 8] = dd[8*i +: 8];
        mmem[int'(off >> 3)] = w;
      end else begin
        q_data.push_back('0);
        dox = 1;
      end
    end
    if ((io || dox) && !m_err) m_erra = dox ? da : ia;
    if (io || dox) m_err = 1;
    pop  = (mcount > 0) && rdy;
    push = de && din && (dw != 8'h00);
    if (push && mcount == LDEPTH && !pop) m_ovf = 1;
    else if (push) begin
      q_log.push_back({dw, da & ~32'h7, dd});
      mcount++;
    end
    if (pop) mcount--;
    @(posedge clock);
    #1;
    vis_count = mcount;
    vis_ovf   = m_ovf;
    vis_err   = m_err;
    vis_erra  = m_erra;
  endtask

  task automatic idle(bit rdy);
    cyc(0, 32'h0, 0, 8'h00, 32'h0, 64'h0, rdy);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] oob_tbl [4];
    oob_tbl[0] = BASE - 32'd8;
    oob_tbl[1] = BASE + SPAN;
    oob_tbl[2] = BASE + SPAN + 32'd4;
    oob_tbl[3] = 32'h0000_0100;
    if ($urandom_range(0, 15) == 0) return oob_tbl[$urandom_range(0, 3)];
    return BASE + 32'($urandom_range(0, WIN - 1) * 8) + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    bus.inst_sram_en = 0; bus.inst_sram_wen = '0; bus.inst_sram_addr = '0;
    bus.inst_sram_wdata = '0; bus.data_sram_en = 0; bus.data_sram_wen = '0;
    bus.data_sram_addr = '0; bus.data_sram_wdata = '0; bus.log_ready = 0;

    repeat (2) @(negedge clock);
    chk("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
    chk("rst_data_rdata", bus.data_sram_rdata, 64'h0);
    chk("rst_log_valid", bus.log_valid, 1'b0);
    chk("rst_err_addr", bus.err_addr, 32'h0);
    #2 reset = 0;

    for (int w = 0; w < WIN; w++)
      cyc(0, 32'h0, 1, 8'hFF, BASE + 32'(w * 8), {$urandom, $urandom}, 1);

    cyc(0, 32'h0, 1, 8'hFF, 32'h8000_0010, 64'h1122_3344_5566_7788, 1);
    cyc(1, 32'h8000_0014, 1, 8'h00, 32'h8000_0010, 64'h0, 1);
    cyc(1, 32'h8000_0010, 0, 8'h00, 32'h0, 64'h0, 1);
    cyc(0, 32'h0, 1, 8'h0F, 32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    cyc(1, 32'h8000_0010, 1, 8'h00, 32'h8000_0013, 64'h0, 1);
    chk("byte_mask_word", bus.data_sram_rdata, 64'h1122_3344_FFFF_FFFF);
    repeat (4) idle(1);

    for (int k = 0; k < LDEPTH; k++)
      cyc(0, 32'h0, 1, 8'($urandom_range(1, 255)), BASE + 32'($urandom_range(0, WIN - 1) * 8),
          {$urandom, $urandom}, 0);
    cyc(0, 32'h0, 1, 8'hA5, BASE + 32'd24, {$urandom, $urandom}, 1);
    repeat (10) idle(1);

    for (int k = 0; k < LDEPTH + 1; k++)
      cyc(0, 32'h0, 1, 8'($urandom_range(1, 255)), BASE + 32'($urandom_range(0, WIN - 1) * 8),
          {$urandom, $urandom}, 0);
    chk("full_log_valid", bus.log_valid, 1'b1);
    chk("full_log_overflow", bus.log_overflow, 1'b1);
    repeat (10) idle(1);

    cyc(0, 32'h0, 1, 8'h00, 32'h7FFF_FFF8, 64'h0, 1);
    cyc(1, 32'h8000_8000, 1, 8'hFF, 32'h8000_8008, 64'h1234, 1);
    chk("oob_err_addr", bus.err_addr, 32'h7FFF_FFF8);
    idle(1);

    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), pick_addr(),
          {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    repeat (12) idle(1);

    for (int k = 0; k < 5; k++)
      cyc(1, BASE + 32'(k * 8 + 4), 1, 8'hFF, BASE + 32'((k + 4) * 8), {$urandom, $urandom}, 0);
    bus.inst_sram_en = 0;
    bus.data_sram_en = 0;
    @(negedge clock);
    #2 reset = 1;
    #1;
    chk("arst_log_valid", bus.log_valid, 1'b0);
    chk("arst_err_oob", bus.err_oob, 1'b0);
    chk("arst_inst_rdata", bus.inst_sram_rdata, 32'h0);
    chk("arst_data_rdata", bus.data_sram_rdata, 64'h0);
    q_inst.delete(); q_data.delete(); q_log.delete();
    mcount = 0; m_ovf = 0; m_err = 0; m_erra = '0;
    vis_count = 0; vis_ovf = 0; vis_err = 0; vis_erra = '0;
    @(negedge clock);
    #2 reset = 0;
    cyc(1, BASE + 32'd32, 1, 8'h00, BASE + 32'd40, 64'h0, 1);
    cyc(1, BASE + 32'd44, 1, 8'h00, BASE + 32'd56, 64'h0, 1);
    repeat (4) idle(1);

    chk("left_log", 104'(q_log.size()), 104'h0);
    chk("left_reads", 104'(q_inst.size() + q_data.size()), 104'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
